ahb3lite_cmd_master: RTL and testbench

Single-beat AHB3-Lite master that turns a simple valid/ready command stream into pipelined NONSEQ transfers toward the SRAM slave (ahb3lite_sram1rw), and returns one in-order response per command. It is the stage directly upstream of the SRAM slave, replacing bench-driven bus stimulus in system configurations. It overlaps the address phase of command N+1 with the data phase of command N, honours slave wait states, and handles the two-cycle ERROR response.

---
 rtl/ahb3lite_pkg.sv | 55 +++++
 rtl/ahb3lite_wait_watchdog.sv | 43 ++++
 rtl/ahb3lite_cmd_master.sv | 133 +++++++++++++
 tb/tb_ahb3lite_cmd_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, pipeline records and address/size helpers
// for the command-stream bus master.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase record: everything needed to (re)issue a transfer.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } aph_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] wdata;
  } dph_t;

  function automatic logic [2:0] cmd_to_hsize(input logic [1:0] size);
    logic [2:0] hsize;
    case (size)
      2'd0:    hsize = HSIZE_BYTE;
      2'd1:    hsize = HSIZE_HWORD;
      default: hsize = HSIZE_WORD;
    endcase
    return hsize;
  endfunction

  // Force natural alignment so the slave never sees a misaligned HADDR.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] hsize);
    logic [31:0] aligned;
    case (hsize)
      HSIZE_BYTE:  aligned = addr;
      HSIZE_HWORD: aligned = {addr[31:1], 1'b0};
      default:     aligned = {addr[31:2], 2'b00};
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/ahb3lite_wait_watchdog.sv
// Counts consecutive stalled data-phase cycles and raises a sticky flag
// once the count reaches TIMEOUT. TIMEOUT of zero disables the flag.
module ahb3lite_wait_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cycle,
  output logic timeout_err
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!wait_cycle) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if ((TIMEOUT != 0) && wait_cycle && (cnt_d == Limit)) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_err = flag_q;

endmodule

// File: rtl/ahb3lite_cmd_master.sv
// Single-beat AHB3-Lite master: valid/ready commands become pipelined NONSEQ
// transfers, with one in-order response per command.
module ahb3lite_cmd_master #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  // Command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  // Response stream
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timeout_err,
  output logic        busy,
  // AHB3-Lite master interface
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  import ahb3lite_pkg::*;

  aph_t        aph_q, aph_d;
  dph_t        dph_q, dph_d;
  logic        cancel_q, cancel_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        accept;
  logic        retire;
  logic [2:0]  cmd_hsize;

  assign cmd_ready = ~HRESET & (~aph_q.valid | (HREADY & ~cancel_q));
  assign accept    = cmd_valid & cmd_ready;
  assign retire    = dph_q.valid & HREADY;
  assign cmd_hsize = cmd_to_hsize(cmd_size);

  always_comb begin
    aph_d    = aph_q;
    dph_d    = dph_q;
    cancel_d = cancel_q;

    if (HREADY) begin
      dph_d.valid = 1'b0;
      // A cancelled address phase was driven as IDLE, so it stays in APH.
      if (!cancel_q && aph_q.valid) begin
        dph_d.valid = 1'b1;
        dph_d.write = aph_q.write;
        dph_d.wdata = aph_q.wdata;
        aph_d.valid = 1'b0;
      end
      cancel_d = 1'b0;
    end else if ((HRESP == HRESP_ERROR) && aph_q.valid) begin
      // First ERROR cycle: pull the pending transfer off the bus next cycle.
      cancel_d = 1'b1;
    end

    if (accept) begin
      aph_d.valid = 1'b1;
      aph_d.addr  = align_addr(cmd_addr, cmd_hsize);
      aph_d.write = cmd_write;
      aph_d.size  = cmd_hsize;
      aph_d.wdata = cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      aph_q    <= '0;
      dph_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      aph_q    <= aph_d;
      dph_q    <= dph_d;
      cancel_q <= cancel_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= retire;
      if (retire) begin
        rsp_rdata_q <= dph_q.write ? 32'h0 : HRDATA;
        rsp_err_q   <= HRESP;
      end
    end
  end

  ahb3lite_wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (HCLK),
    .rst         (HRESET),
    .wait_cycle  (dph_q.valid & ~HREADY),
    .timeout_err (timeout_err)
  );

  assign HTRANS    = (aph_q.valid && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL      = HTRANS[1];
  assign HADDR     = aph_q.addr;
  assign HWRITE    = aph_q.write;
  assign HSIZE     = aph_q.size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dph_q.wdata;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = aph_q.valid | dph_q.valid;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Scoreboard bench for ahb3lite_cmd_master with a behavioural SRAM slave
// that can insert wait states and two-cycle ERROR responses.
module tb_ahb3lite_cmd_master;
  import ahb3lite_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err, timeout_err, busy;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb3lite_cmd_master #(
    .HPROT_VAL (4'b0011),
    .TIMEOUT   (8)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .timeout_err (timeout_err),
    .busy        (busy),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HTRANS      (HTRANS),
    .HMASTLOCK   (HMASTLOCK),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
  } xfer_t;

  exp_t  exp_q[$];
  xfer_t bus_log[$];
  int    rsp_cyc[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  // Slave model state
  logic [31:0] mem [0:63];
  int          wait_cfg = 0;
  bit          err_cfg = 0;
  bit          dp_act, dp_write, dp_err, err2;
  logic [31:0] dp_addr;
  int          wait_left, err_now, low_run;
  logic [1:0]  p_trans;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_size;
  logic        p_write;

  int n, st, st_sum, idx, r0, c44, nb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Behavioural slave: updates at negedge from what the bus held last cycle.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[17] = 32'h4444_4444;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    dp_act = 0; dp_write = 0; dp_err = 0; err2 = 0; dp_addr = 32'h0;
    wait_left = 0; err_now = 0; low_run = 0;
    p_trans = HTRANS_IDLE; p_addr = 32'h0; p_wdata = 32'h0; p_size = 3'b0; p_write = 1'b0;
    forever begin
      @(negedge HCLK);
      err2 = 0;
      if (HRESET) begin
        dp_act = 0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; low_run = 0; err_now = 0;
      end else begin
        if (HREADY) begin
          if (dp_act && dp_write && !dp_err) mem[dp_addr[7:2]] = p_wdata;
          dp_act = 0;
          if (p_trans == HTRANS_NONSEQ) begin
            dp_act = 1; dp_addr = p_addr; dp_write = p_write; dp_err = err_cfg;
            err_now = err_cfg ? 1 : 0; wait_left = wait_cfg;
            err_cfg = 0; wait_cfg = 0;
            bus_log.push_back('{cyc, p_addr, p_size, p_write});
          end
        end
        HRESP = 1'b0; HRDATA = 32'h0;
        if (!dp_act) HREADY = 1'b1;
        else if (wait_left > 0) begin HREADY = 1'b0; wait_left--; end
        else if (err_now == 1) begin HREADY = 1'b0; HRESP = 1'b1; err_now = 2; end
        else if (err_now == 2) begin HREADY = 1'b1; HRESP = 1'b1; err_now = 0; err2 = 1; end
        else begin
          HREADY = 1'b1;
          if (!dp_write) HRDATA = mem[dp_addr[7:2]];
        end
        low_run = (!HREADY && dp_act) ? low_run + 1 : 0;
      end
      p_trans = HTRANS; p_addr = HADDR; p_size = HSIZE; p_write = HWRITE; p_wdata = HWDATA;
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input bit exp_rsp, input logic [31:0] er,
                      input logic ee, output int stalls);
    exp_t e;
    bit   done;
    stalls = 0;
    done   = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    while (!done) begin
      @(negedge HCLK); #3;
      if (cmd_ready) done = 1;
      else begin
        stalls++;
        if (stalls > 40) begin fail_now("send_timeout"); done = 1; end
      end
    end
    if (exp_rsp) begin
      e.rdata = er; e.err = ee;
      exp_q.push_back(e);
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge HCLK); #2;
      k++;
    end while ((busy || exp_q.size() != 0) && k < 60);
    if (k >= 60) fail_now("idle_timeout");
    @(posedge HCLK); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_htrans"},    32'(HTRANS),      32'(HTRANS_IDLE));
    chk({tag, "_haddr"},     HADDR,            32'h0);
    chk({tag, "_hwrite"},    32'(HWRITE),      32'h0);
    chk({tag, "_hsize"},     32'(HSIZE),       32'h0);
    chk({tag, "_hwdata"},    HWDATA,           32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),   32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,        32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err),     32'h0);
    chk({tag, "_timeout"},   32'(timeout_err), 32'h0);
    chk({tag, "_busy"},      32'(busy),        32'h0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready),   32'h0);
  endtask

  initial begin
    HRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'd0; cmd_wdata = 32'h0;
    #3;
    check_reset("rst0");
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    chk("hsel_idle", 32'(HSEL), 32'h0);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Write then read back on consecutive cycles
    idx = bus_log.size();
    send(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, st);
    send(1'b0, 32'h10, 2'd2, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, st);
    wait_idle();
    chk("t1_log_count", 32'(bus_log.size() - idx), 32'd2);
    if (bus_log.size() >= idx + 2) begin
      chk("t1_addr0", bus_log[idx].addr, 32'h10);
      chk("t1_write0", 32'(bus_log[idx].write), 32'h1);
      chk("t1_write1", 32'(bus_log[idx+1].write), 32'h0);
      chk("t1_consecutive", 32'(bus_log[idx+1].cyc - bus_log[idx].cyc), 32'd1);
    end

    // Four back-to-back writes, zero-wait slave
    r0 = rsp_cyc.size();
    st_sum = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'(i * 4), 2'd2, 32'h1000_0000 + 32'(i), 1, 32'h0, 1'b0, st);
      st_sum += st;
    end
    wait_idle();
    chk("b2b_stalls", 32'(st_sum), 32'd0);
    chk("b2b_rsp_count", 32'(rsp_cyc.size() - r0), 32'd4);
    if (rsp_cyc.size() >= r0 + 4) chk("b2b_rsp_span", 32'(rsp_cyc[r0+3] - rsp_cyc[r0]), 32'd3);

    // Three wait states on read @0x20 with a write @0x24 queued behind it
    send(1'b1, 32'h20, 2'd2, 32'h1234_5678, 1, 32'h0, 1'b0, st);
    wait_idle();
    wait_cfg = 3;
    fork
      begin
        send(1'b0, 32'h20, 2'd2, 32'h55AA_55AA, 1, 32'h1234_5678, 1'b0, st);
        send(1'b1, 32'h24, 2'd2, 32'h0BAD_F00D, 1, 32'h0, 1'b0, st);
      end
      begin
        nb = 0;
        do begin @(negedge HCLK); #3; nb++; end while (low_run != 1 && nb < 20);
        if (nb >= 20) fail_now("ws_no_wait");
        for (int i = 0; i < 3; i++) begin
          chk("ws_haddr", HADDR, 32'h24);
          chk("ws_hwdata", HWDATA, 32'h55AA_55AA);
          chk("ws_cmd_ready", 32'(cmd_ready), 32'h0);
          chk("ws_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
          @(negedge HCLK); #3;
        end
      end
    join
    wait_idle();

    // ERROR on write @0x40 with read @0x44 pending
    idx = bus_log.size();
    err_cfg = 1;
    fork
      begin
        send(1'b1, 32'h40, 2'd2, 32'h0, 1, 32'h0, 1'b1, st);
        send(1'b0, 32'h44, 2'd2, 32'h0, 1, 32'h4444_4444, 1'b0, st);
      end
      begin
        nb = 0;
        do begin @(negedge HCLK); #3; nb++; end while (!err2 && nb < 20);
        if (nb >= 20) fail_now("err_no_second_cycle");
        chk("err_htrans_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("err_hsel", 32'(HSEL), 32'h0);
        chk("err_haddr_held", HADDR, 32'h44);
        chk("err_cmd_ready", 32'(cmd_ready), 32'h0);
        @(negedge HCLK); #3;
        chk("err_reissue", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        chk("err_reissue_addr", HADDR, 32'h44);
      end
    join
    wait_idle();
    c44 = 0;
    for (int i = idx; i < bus_log.size(); i++) if (bus_log[i].addr == 32'h44) c44++;
    chk("err_44_once", 32'(c44), 32'd1);

    // Sub-word alignment
    idx = bus_log.size();
    send(1'b1, 32'h13, 2'd0, 32'hAB00_0000, 1, 32'h0, 1'b0, st);
    send(1'b1, 32'h13, 2'd1, 32'hCDEF_0000, 1, 32'h0, 1'b0, st);
    wait_idle();
    chk("sz_log_count", 32'(bus_log.size() - idx), 32'd2);
    if (bus_log.size() >= idx + 2) begin
      chk("sz_byte_addr", bus_log[idx].addr, 32'h13);
      chk("sz_byte_size", 32'(bus_log[idx].size), 32'h0);
      chk("sz_hword_addr", bus_log[idx+1].addr, 32'h12);
      chk("sz_hword_size", 32'(bus_log[idx+1].size), 32'h1);
    end

    // Watchdog at 8 stalled cycles, then reset mid-wait (no response expected)
    wait_cfg = 20;
    send(1'b0, 32'h30, 2'd2, 32'h0, 0, 32'h0, 1'b0, st);
    n = 0;
    do begin @(negedge HCLK); #2; n++; end while (low_run != 8 && n < 40);
    if (n >= 40) fail_now("wd_no_stall");
    chk("wd_before", 32'(timeout_err), 32'h0);
    chk("wd_busy", 32'(busy), 32'h1);
    @(negedge HCLK); #2;
    chk("wd_set", 32'(timeout_err), 32'h1);
    HRESET = 1'b1;
    #1;
    check_reset("rst1");
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Recovery after reset
    send(1'b1, 32'h50, 2'd2, 32'h600D_CAFE, 1, 32'h0, 1'b0, st);
    send(1'b0, 32'h50, 2'd2, 32'h0, 1, 32'h600D_CAFE, 1'b0, st);
    wait_idle();
    chk("post_rst_timeout", 32'(timeout_err), 32'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge HCLK); n++; end
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
